// File: rtl/vga_write_scheduler.sv
// Write scheduler for the VGA console and image buffers: bus writes are queued in a FIFO
// and drained in arrival order. Console writes wait out scrolling and are followed by a guard gap.
module vga_write_scheduler #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 14,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     wr_is_image,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     scroll,
    output logic                     console_we,
    output logic [7:0]               console_wdata,
    output logic                     image_we,
    output logic [ADDR_W-1:0]        image_addr,
    output logic [7:0]               image_wdata,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 9;

    typedef enum logic [1:0] {IDLE, WAIT_SCROLL, GAP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          gap_q, gap_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                console_we_q, console_we_d;
    logic [7:0]          console_wdata_q, console_wdata_d;
    logic                image_we_q, image_we_d;
    logic [ADDR_W-1:0]   image_addr_q, image_addr_d;
    logic [7:0]          image_wdata_q, image_wdata_d;

    logic [ENT_W-1:0]    mem_q [DEPTH];
    logic [ENT_W-1:0]    head;
    logic                head_is_image;
    logic [ADDR_W-1:0]   head_addr;
    logic [7:0]          head_data;
    logic                push;
    logic                pop;
    logic                fifo_empty;

    // Ready looks only at the registered level, so a full FIFO never accepts, even on a pop.
    assign wr_ready      = !HRESET && (level_q < LVL_W'(DEPTH));
    assign push          = wr_valid && wr_ready;
    assign fifo_empty    = (level_q == '0);
    assign head          = mem_q[rd_ptr_q];
    assign head_is_image = head[ENT_W-1];
    assign head_addr     = head[ADDR_W+7:8];
    assign head_data     = head[7:0];

    // Storage carries no reset; the pointers and level define which entries are live.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_is_image, wr_addr, wr_data};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_comb begin
        state_d         = state_q;
        gap_d           = gap_q;
        pop             = 1'b0;
        console_we_d    = 1'b0;
        console_wdata_d = 8'h00;
        image_we_d      = 1'b0;
        image_addr_d    = '0;
        image_wdata_d   = 8'h00;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_is_image) begin
                        image_we_d    = 1'b1;
                        image_addr_d  = head_addr;
                        image_wdata_d = head_data;
                        pop           = 1'b1;
                    end else if (!scroll) begin
                        console_we_d    = 1'b1;
                        console_wdata_d = head_data;
                        pop             = 1'b1;
                        gap_d           = 4'(GAP_CYCLES);
                        state_d         = GAP;
                    end else begin
                        state_d = WAIT_SCROLL;
                    end
                end
            end
            WAIT_SCROLL: begin
                if (!scroll) begin
                    console_we_d    = 1'b1;
                    console_wdata_d = head_data;
                    pop             = 1'b1;
                    gap_d           = 4'(GAP_CYCLES);
                    state_d         = GAP;
                end
            end
            GAP: begin
                // IDLE is entered as the count hits zero; the next issue follows from IDLE.
                gap_d = gap_q - 4'd1;
                if (gap_q <= 4'd1) begin
                    gap_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q         <= IDLE;
            gap_q           <= 4'd0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            console_we_q    <= 1'b0;
            console_wdata_q <= 8'h00;
            image_we_q      <= 1'b0;
            image_addr_q    <= '0;
            image_wdata_q   <= 8'h00;
        end else begin
            state_q         <= state_d;
            gap_q           <= gap_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            console_we_q    <= console_we_d;
            console_wdata_q <= console_wdata_d;
            image_we_q      <= image_we_d;
            image_addr_q    <= image_addr_d;
            image_wdata_q   <= image_wdata_d;
        end
    end

    assign console_we    = console_we_q;
    assign console_wdata = console_wdata_q;
    assign image_we      = image_we_q;
    assign image_addr    = image_addr_q;
    assign image_wdata   = image_wdata_q;
    assign fifo_level    = level_q;
    assign busy          = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_vga_write_scheduler.sv
// Scoreboard bench for vga_write_scheduler: directed pushes queue expected writes,
// a negedge monitor pops and compares every strobe the DUT presents.
module tb_vga_write_scheduler;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 14;
    localparam int GAP    = 2;

    logic              HCLK = 1'b0;
    logic              HRESET = 1'b1;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic              wr_is_image = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [7:0]        wr_data = 8'h00;
    logic              scroll = 1'b0;
    logic              console_we;
    logic [7:0]        console_wdata;
    logic              image_we;
    logic [ADDR_W-1:0] image_addr;
    logic [7:0]        image_wdata;
    logic [3:0]        fifo_level;
    logic              busy;

    vga_write_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_is_image(wr_is_image), .wr_addr(wr_addr), .wr_data(wr_data), .scroll(scroll),
        .console_we(console_we), .console_wdata(console_wdata), .image_we(image_we),
        .image_addr(image_addr), .image_wdata(image_wdata), .fifo_level(fifo_level), .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int strobes = 0;
    int last_con = -100;
    int con_cycles[$];
    logic [22:0] exp_q[$];

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected write.
    always @(negedge HCLK) begin
        if (HRESET) begin
            last_con = -100;
        end else begin
            if (console_we || image_we) begin
                logic [22:0] e;
                strobes++;
                chk("one_strobe", int'(console_we && image_we), 0);
                chk("gap_respected", int'(cyc - last_con > GAP), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", int'(image_we), int'(e[22]));
                    if (e[22]) begin
                        chk("image_addr", int'(image_addr), int'(e[21:8]));
                        chk("image_data", int'(image_wdata), int'(e[7:0]));
                    end else begin
                        chk("console_data", int'(console_wdata), int'(e[7:0]));
                    end
                end
                if (console_we) begin
                    last_con = cyc;
                    con_cycles.push_back(cyc);
                end
                $display("strobe cyc=%0d con=%0b cdata=%02h img=%0b addr=%04h idata=%02h",
                         cyc, console_we, console_wdata, image_we, image_addr, image_wdata);
            end
            if (!console_we) chk("console_data_idle_zero", int'(console_wdata), 0);
            if (!image_we)   chk("image_idle_zero", int'({image_addr, image_wdata}), 0);
        end
    end

    task automatic push(input bit img, input logic [13:0] a, input logic [7:0] d, input bit exp_acc);
        @(negedge HCLK);
        wr_valid = 1'b1; wr_is_image = img; wr_addr = a; wr_data = d;
        chk("wr_ready", int'(wr_ready), int'(exp_acc));
        if (exp_acc) exp_q.push_back({img, a, d});
        $display("push img=%0b addr=%04h data=%02h accept_expected=%0b", img, a, d, exp_acc);
        @(posedge HCLK);
        #1 wr_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge HCLK);
            n++;
        end
        chk({name, "_drain_done"}, int'(exp_q.size() == 0 && !busy), 1);
    endtask

    initial begin
        int s0;
        // Reset state
        #2;
        chk("rst_wr_ready", int'(wr_ready), 0);
        chk("rst_outputs", int'({console_we, image_we, fifo_level, busy}), 0);
        repeat (2) @(posedge HCLK);
        #2 HRESET = 1'b0;
        #1 chk("post_rst_wr_ready", int'(wr_ready), 1);

        // Single image write: level/busy, then strobe exactly the cycle after the next edge
        push(1'b1, 14'h0123, 8'hE0, 1'b1);
        @(negedge HCLK);
        chk("t1_level_after_push", int'(fifo_level), 1);
        chk("t1_busy_after_push", int'(busy), 1);
        chk("t1_no_strobe_yet", int'(image_we), 0);
        @(negedge HCLK);
        chk("t1_image_we", int'(image_we), 1);
        chk("t1_image_addr", int'(image_addr), 16'h0123);
        chk("t1_image_data", int'(image_wdata), 8'hE0);
        chk("t1_level_zero", int'(fifo_level), 0);
        @(negedge HCLK);
        chk("t1_one_cycle", int'(image_we), 0);
        chk("t1_busy_low", int'(busy), 0);

        // Four back-to-back image writes
        s0 = strobes;
        for (int i = 0; i < 4; i++) push(1'b1, 14'(16'h0200 + i), 8'(8'h11 * (i + 1)), 1'b1);
        drain("t2", 20);
        chk("t2_strobe_count", strobes - s0, 4);

        // Two console writes separated by exactly GAP idle cycles
        con_cycles.delete();
        push(1'b0, 14'h0, 8'h41, 1'b1);
        push(1'b0, 14'h0, 8'h42, 1'b1);
        drain("t3", 20);
        chk("t3_two_console", con_cycles.size(), 2);
        if (con_cycles.size() == 2) chk("t3_separation", con_cycles[1] - con_cycles[0], GAP + 1);

        // Blocked console entry holds the image behind it
        scroll = 1'b1;
        push(1'b0, 14'h0, 8'h43, 1'b1);
        push(1'b1, 14'h0010, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            chk("t4_blocked_no_strobe", int'(console_we || image_we), 0);
            chk("t4_level2", int'(fifo_level), 2);
        end
        scroll = 1'b0;
        @(negedge HCLK);
        chk("t4_console_we", int'(console_we), 1);
        chk("t4_console_data", int'(console_wdata), 8'h43);
        repeat (GAP) begin
            @(negedge HCLK);
            chk("t4_gap_idle", int'(console_we || image_we), 0);
        end
        @(negedge HCLK);
        chk("t4_image_after_gap", int'(image_we), 1);
        chk("t4_image_data", int'(image_wdata), 8'h55);
        drain("t4", 10);

        // Overflow: DEPTH+2 pushes while blocked, exactly DEPTH accepted
        scroll = 1'b1;
        s0 = strobes;
        for (int i = 0; i < DEPTH + 2; i++)
            push(1'(i % 3 != 0), 14'(16'h0300 + i), 8'(8'hA0 + i), i < DEPTH);
        @(negedge HCLK);
        chk("t5_level_full", int'(fifo_level), DEPTH);
        chk("t5_ready_low_full", int'(wr_ready), 0);
        scroll = 1'b0;
        drain("t5", 60);
        chk("t5_strobe_count", strobes - s0, DEPTH);

        // Reset mid-drain with five entries queued
        scroll = 1'b1;
        push(1'b0, 14'h0, 8'h50, 1'b1);
        for (int i = 0; i < 4; i++) push(1'b1, 14'(16'h0400 + i), 8'(8'hC0 + i), 1'b1);
        @(negedge HCLK);
        chk("t6_level5", int'(fifo_level), 5);
        scroll = 1'b0;
        @(negedge HCLK);
        chk("t6_console_in_flight", int'(console_we), 1);
        #2 HRESET = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_strobe_drop", int'(console_we || image_we), 0);
        chk("t6_level_zero", int'(fifo_level), 0);
        chk("t6_ready_in_reset", int'(wr_ready), 0);
        chk("t6_busy_zero", int'(busy), 0);
        @(posedge HCLK);
        #2 HRESET = 1'b0;
        #1 chk("t6_ready_after", int'(wr_ready), 1);
        s0 = strobes;
        repeat (10) @(negedge HCLK);
        chk("t6_no_stale", strobes - s0, 0);
        chk("t6_level_still_zero", int'(fifo_level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
